// File: rtl/aes_host_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_host_pkg
// Description : Shared types, sizes and helpers for the AES S-box host.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_host_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_KREQ  = 3'd1,
        ST_KWAIT = 3'd2,
        ST_FILL  = 3'd3,
        ST_LOAD  = 3'd4,
        ST_HOLD  = 3'd5,
        ST_WAIT  = 3'd6
    } state_t;

    localparam int          LANES     = 23;
    localparam int          LANE_W    = 16;
    localparam int          DIN_W     = 496;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // MSB index of randomness lane i; lane 0 sits at the top of Din.
    function automatic logic [8:0] lane_off(input logic [4:0] i);
        return 9'(DIN_W - 1 - LANE_W * int'(i));
    endfunction

    // Right-shifting Galois step for x^32+x^22+x^2+x+1.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_host_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : aes_host_lfsr
// Description : 32-bit Galois LFSR mask generator with seed load and enable.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_host_lfsr
    import aes_host_pkg::*;
#(
    parameter logic [31:0] SEED_RST = 32'hACE1_2468
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_ld,
    input  logic [31:0] i_seed,
    input  logic        i_en,
    output logic [31:0] o_state
);

    logic [31:0] r_state;

    // A zero seed would lock the register at zero forever, so it is replaced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SEED_RST;
        end else if (i_ld) begin
            r_state <= (i_seed == 32'h0) ? SEED_RST : i_seed;
        end else if (i_en) begin
            r_state <= lfsr_step(r_state);
        end
    end

    assign o_state = r_state;

endmodule
`default_nettype wire

// File: rtl/aes_sbox_host.sv
`default_nettype none
// ============================================================================
// Module      : aes_sbox_host
// Description : Host initiator driving a masked-S-box AES core handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_sbox_host
    import aes_host_pkg::*;
#(
    parameter int          TIMEOUT  = 1024,
    parameter logic [31:0] SEED_RST = 32'hACE1_2468
) (
    input  logic               CLK,
    input  logic               RSTn,
    input  logic [127:0]       key_data,
    input  logic               key_valid,
    output logic               key_ready,
    input  logic [127:0]       pt_data,
    input  logic               pt_valid,
    output logic               pt_ready,
    input  logic [31:0]        seed_data,
    input  logic               seed_ld,
    output logic [127:0]       ct_data,
    output logic               ct_valid,
    output logic               err_timeout,
    output logic [127:0]       Kin,
    output logic [DIN_W-1:0]   Din,
    output logic               Krdy,
    output logic               Drdy,
    output logic               EN,
    input  logic               Kvld,
    input  logic               Dvld,
    input  logic               BSY,
    input  logic [127:0]       Dout
);

    state_t             r_state;
    logic               r_rdy;
    logic               r_en;
    logic               r_krdy;
    logic               r_drdy;
    logic               r_ct_valid;
    logic               r_err;
    logic [127:0]       r_kin;
    logic [DIN_W-1:0]   r_din;
    logic [127:0]       r_ct;
    logic [4:0]         r_lane;
    logic [15:0]        r_cnt;

    logic [31:0]        w_lfsr;
    logic [31:0]        w_lfsr_nxt;
    logic [15:0]        w_cnt_nxt;
    logic               w_unused;

    aes_host_lfsr #(
        .SEED_RST (SEED_RST)
    ) u_lfsr (
        .clk     (CLK),
        .rst_n   (RSTn),
        .i_ld    (seed_ld && (r_state == ST_IDLE)),
        .i_seed  (seed_data),
        .i_en    (r_state == ST_FILL),
        .o_state (w_lfsr)
    );

    // Lanes take the value the LFSR advances to in the same cycle.
    assign w_lfsr_nxt = lfsr_step(w_lfsr);
    assign w_cnt_nxt  = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
    assign w_unused   = ^{BSY, w_lfsr_nxt[31:LANE_W]};

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state    <= ST_IDLE;
            r_rdy      <= 1'b1;
            r_en       <= 1'b0;
            r_krdy     <= 1'b0;
            r_drdy     <= 1'b0;
            r_ct_valid <= 1'b0;
            r_err      <= 1'b0;
            r_kin      <= '0;
            r_din      <= '0;
            r_ct       <= '0;
            r_lane     <= '0;
            r_cnt      <= '0;
        end else begin
            r_en       <= 1'b1;
            r_krdy     <= 1'b0;
            r_drdy     <= 1'b0;
            r_ct_valid <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (key_valid) begin
                        r_kin   <= key_data;
                        r_krdy  <= 1'b1;
                        r_rdy   <= 1'b0;
                        r_state <= ST_KREQ;
                    end else if (pt_valid) begin
                        r_din[127:0] <= pt_data;
                        r_lane       <= '0;
                        r_rdy        <= 1'b0;
                        r_state      <= ST_FILL;
                    end
                end
                ST_KREQ: r_state <= ST_KWAIT;
                ST_KWAIT: begin
                    if (Kvld) begin
                        r_rdy   <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                ST_FILL: begin
                    r_din[lane_off(r_lane) -: LANE_W] <= w_lfsr_nxt[LANE_W-1:0];
                    r_lane <= r_lane + 5'd1;
                    if (r_lane == 5'(LANES - 1)) begin
                        r_drdy  <= 1'b1;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: r_state <= ST_HOLD;
                ST_HOLD: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A result arriving on the final allowed cycle still wins.
                    if (Dvld) begin
                        r_ct       <= Dout;
                        r_ct_valid <= 1'b1;
                        r_rdy      <= 1'b1;
                        r_state    <= ST_IDLE;
                    end else if (w_cnt_nxt == 16'(TIMEOUT)) begin
                        r_err   <= 1'b1;
                        r_rdy   <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                    end
                end
                default: begin
                    r_rdy   <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign key_ready   = r_rdy;
    assign pt_ready    = r_rdy;
    assign ct_data     = r_ct;
    assign ct_valid    = r_ct_valid;
    assign err_timeout = r_err;
    assign Kin         = r_kin;
    assign Din         = r_din;
    assign Krdy        = r_krdy;
    assign Drdy        = r_drdy;
    assign EN          = r_en;

endmodule
`default_nettype wire

// File: tb/tb_aes_sbox_host.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_sbox_host
// Description : Directed self-checking bench for aes_sbox_host.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_sbox_host;

    localparam int          TIMEOUT  = 1024;
    localparam logic [31:0] SEED_RST = 32'hACE1_2468;

    logic         CLK;
    logic         RSTn;
    logic [127:0] key_data;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] pt_data;
    logic         pt_valid;
    logic         pt_ready;
    logic [31:0]  seed_data;
    logic         seed_ld;
    logic [127:0] ct_data;
    logic         ct_valid;
    logic         err_timeout;
    logic [127:0] Kin;
    logic [495:0] Din;
    logic         Krdy;
    logic         Drdy;
    logic         EN;
    logic         Kvld;
    logic         Dvld;
    logic         BSY;
    logic [127:0] Dout;

    int           checks   = 0;
    int           failures = 0;
    int           t_off    = 0;
    logic [31:0]  m_lfsr;
    logic [127:0] exp_kin;
    logic [127:0] last_ct;
    logic [127:0] last_pt;
    logic [127:0] sb_q[$];

    aes_sbox_host #(
        .TIMEOUT  (TIMEOUT),
        .SEED_RST (SEED_RST)
    ) dut (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .key_data    (key_data),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .pt_data     (pt_data),
        .pt_valid    (pt_valid),
        .pt_ready    (pt_ready),
        .seed_data   (seed_data),
        .seed_ld     (seed_ld),
        .ct_data     (ct_data),
        .ct_valid    (ct_valid),
        .err_timeout (err_timeout),
        .Kin         (Kin),
        .Din         (Din),
        .Krdy        (Krdy),
        .Drdy        (Drdy),
        .EN          (EN),
        .Kvld        (Kvld),
        .Dvld        (Dvld),
        .BSY         (BSY),
        .Dout        (Dout)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] m_step(input logic [31:0] s);
        m_step = {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    task automatic check(input string tag, input logic [495:0] obs, input logic [495:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Each step lands on a falling edge: outputs are stable, inputs set here hit the next rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(negedge CLK);
            t_off++;
        end
    endtask

    task automatic load_key(input logic [127:0] k);
        key_data  = k;
        key_valid = 1'b1;
        t_off     = 0;
        step(1);
        key_valid = 1'b0;
        check("krdy_t1", Krdy, 1'b1);
        check("key_ready_low", key_ready, 1'b0);
        step(1);
        Kvld = 1'b1;
        check("krdy_t2", Krdy, 1'b0);
        check("kin_latched", Kin, k);
        step(1);
        Kvld = 1'b0;
        check("key_ready_t3", key_ready, 1'b1);
        exp_kin = k;
    endtask

    task automatic load_seed(input logic [31:0] s);
        seed_data = s;
        seed_ld   = 1'b1;
        step(1);
        seed_ld   = 1'b0;
        m_lfsr    = (s == 32'h0) ? SEED_RST : s;
    endtask

    // Drives a plaintext and returns at the first WAIT cycle (t+26).
    task automatic pt_to_wait(input logic [127:0] pt, input bit spurious);
        logic [495:0] exp_din;
        exp_din        = '0;
        exp_din[127:0] = pt;
        for (int i = 0; i < 23; i++) begin
            m_lfsr = m_step(m_lfsr);
            exp_din[495 - 16 * i -: 16] = m_lfsr[15:0];
        end
        pt_data  = pt;
        pt_valid = 1'b1;
        t_off    = 0;
        step(1);
        pt_valid = 1'b0;
        check("pt_ready_fill", pt_ready, 1'b0);
        check("din_pt_latch", Din[127:0], pt);
        if (spurious) begin
            Dvld = 1'b1;
            Dout = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;
            step(1);
            Dvld = 1'b0;
            step(1);
            check("no_ct_spurious", ct_valid, 1'b0);
        end
        step(23 - t_off);
        check("drdy_before_load", Drdy, 1'b0);
        step(1);
        check("drdy_load", Drdy, 1'b1);
        check("din_lanes", Din, exp_din);
        check("kin_hold", Kin, exp_kin);
        step(1);
        check("drdy_hold", Drdy, 1'b0);
        check("din_hold", Din[127:0], pt);
        step(1);
        last_pt = pt;
    endtask

    // Scoreboard pop: bounded wait for ct_valid, then compare data and arrival cycle.
    task automatic expect_ct(input int exp_off);
        int           n;
        logic [127:0] exp_ct;
        n = 0;
        while (ct_valid !== 1'b1 && n < 20) begin
            step(1);
            n++;
        end
        check("ct_valid_seen", ct_valid, 1'b1);
        check("ct_valid_time", t_off, exp_off);
        exp_ct = (sb_q.size() != 0) ? sb_q.pop_front() : last_ct;
        check("ct_data", ct_data, exp_ct);
        check("err_with_result", err_timeout, 1'b0);
        last_ct = exp_ct;
        step(1);
        check("ct_valid_pulse", ct_valid, 1'b0);
        check("pt_ready_after", pt_ready, 1'b1);
    endtask

    task automatic run_pt(input logic [127:0] pt, input logic [127:0] resp, input bit spurious);
        sb_q.push_back(resp);
        pt_to_wait(pt, spurious);
        step(34 - t_off);
        Dvld = 1'b1;
        Dout = resp;
        step(1);
        Dvld = 1'b0;
        expect_ct(35);
    endtask

    initial begin
        RSTn      = 1'b0;
        key_data  = '0;
        key_valid = 1'b0;
        pt_data   = '0;
        pt_valid  = 1'b0;
        seed_data = '0;
        seed_ld   = 1'b0;
        Kvld      = 1'b0;
        Dvld      = 1'b0;
        BSY       = 1'b0;
        Dout      = '0;
        m_lfsr    = SEED_RST;
        exp_kin   = '0;
        last_ct   = '0;
        last_pt   = '0;

        // Reset state
        step(3);
        check("rst_en", EN, 1'b0);
        check("rst_krdy", Krdy, 1'b0);
        check("rst_drdy", Drdy, 1'b0);
        check("rst_ct_valid", ct_valid, 1'b0);
        check("rst_err", err_timeout, 1'b0);
        check("rst_kin", Kin, 128'h0);
        check("rst_din", Din, 496'h0);
        check("rst_ct_data", ct_data, 128'h0);
        check("rst_key_ready", key_ready, 1'b1);
        check("rst_pt_ready", pt_ready, 1'b1);
        RSTn = 1'b1;
        step(1);
        check("en_after_release", EN, 1'b1);

        // Key load and first plaintexts with a known seed
        load_key(128'h0001_0203_0405_0607_0809_0A0B_0C0D_0E0F);
        load_seed(32'h0000_0001);
        run_pt(128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF,
               128'hDEAD_BEEF_0123_4567_89AB_CDEF_FEDC_BA98, 1'b1);
        run_pt(128'h1111_2222_3333_4444_5555_6666_7777_8888,
               128'hCAFE_F00D_1357_9BDF_2468_ACE0_0F0F_F0F0, 1'b0);

        // Timeout with no Dvld at all
        pt_to_wait(128'hA5A5_A5A5_5A5A_5A5A_0000_FFFF_1234_5678, 1'b0);
        step(TIMEOUT - 1);
        check("err_before_timeout", err_timeout, 1'b0);
        step(1);
        check("err_pulse", err_timeout, 1'b1);
        check("err_time", t_off, 26 + TIMEOUT);
        check("ct_valid_on_timeout", ct_valid, 1'b0);
        check("ct_data_unchanged", ct_data, last_ct);
        step(1);
        check("err_one_cycle", err_timeout, 1'b0);
        check("pt_ready_after_timeout", pt_ready, 1'b1);

        // Zero seed falls back to the reset seed; next plaintext accepted
        load_seed(32'h0000_0000);
        run_pt(128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0,
               128'h0102_0408_1020_4080_0102_0408_1020_4080, 1'b0);

        // Key beats plaintext when both are offered
        key_data  = 128'hFFEE_DDCC_BBAA_9988_7766_5544_3322_1100;
        key_valid = 1'b1;
        pt_data   = 128'h9999_9999_9999_9999_9999_9999_9999_9999;
        pt_valid  = 1'b1;
        t_off     = 0;
        step(1);
        key_valid = 1'b0;
        pt_valid  = 1'b0;
        check("prio_krdy", Krdy, 1'b1);
        check("prio_kin", Kin, 128'hFFEE_DDCC_BBAA_9988_7766_5544_3322_1100);
        check("prio_din_untouched", Din[127:0], last_pt);
        step(1);
        Kvld = 1'b1;
        step(1);
        Kvld = 1'b0;
        check("prio_key_ready", key_ready, 1'b1);
        exp_kin = 128'hFFEE_DDCC_BBAA_9988_7766_5544_3322_1100;

        // Dvld on the last allowed WAIT cycle wins over the timeout
        sb_q.push_back(128'h7777_0000_7777_0000_7777_0000_7777_0000);
        pt_to_wait(128'h3141_5926_5358_9793_2384_6264_3383_2795, 1'b0);
        step(TIMEOUT - 1);
        Dvld = 1'b1;
        Dout = 128'h7777_0000_7777_0000_7777_0000_7777_0000;
        step(1);
        Dvld = 1'b0;
        check("same_cycle_no_err", err_timeout, 1'b0);
        expect_ct(26 + TIMEOUT);

        // Asynchronous reset while waiting for the core
        pt_to_wait(128'h2718_2818_2845_9045_2353_6028_7471_3527, 1'b0);
        step(2);
        RSTn = 1'b0;
        #1;
        check("arst_en", EN, 1'b0);
        check("arst_drdy", Drdy, 1'b0);
        check("arst_ct_valid", ct_valid, 1'b0);
        check("arst_pt_ready", pt_ready, 1'b1);
        check("arst_kin", Kin, 128'h0);
        check("arst_din", Din, 496'h0);
        step(2);
        RSTn = 1'b1;
        Dvld = 1'b1;
        Dout = 128'h5555_5555_5555_5555_5555_5555_5555_5555;
        step(2);
        Dvld = 1'b0;
        step(1);
        check("no_stale_result", ct_valid, 1'b0);
        check("no_stale_ct_data", ct_data, 128'h0);
        m_lfsr  = SEED_RST;
        exp_kin = '0;
        last_ct = '0;
        run_pt(128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF,
               128'hF00D_CAFE_F00D_CAFE_F00D_CAFE_F00D_CAFE, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes_sbox_host.md
# aes_sbox_host

Host-side initiator for the masked-S-box AES framework core interface (Kin/Din/Krdy/Drdy/Kvld/Dvld/Dout/EN/BSY). It accepts a key and plaintexts over valid/ready streams and generates fresh mask randomness from an internal LFSR. It then packs plaintext and randomness into the 496-bit Din word, runs the Krdy/Drdy handshake into the core, waits for Dvld with a timeout, and returns Dout as a result stream. It sits between the capture/measurement control logic and the core under test.

## Interface
- TIMEOUT, 1024: max cycles in WAIT before abort.
- SEED_RST, 32'hACE1_2468: LFSR value after reset.
- CLK  in  1  system clock, all logic on rising edge.
- RSTn  in  1  asynchronous, active-low reset.
- key_data  in  128  key to load.
- key_valid / key_ready  in / out  1  key handshake; transfer when both high.
- pt_data  in  128  plaintext.
- pt_valid / pt_ready  in / out  1  plaintext handshake.
- seed_data  in  32  LFSR seed; seed_ld  in  1  loads it, IDLE only, ignored elsewhere.
- ct_data  out  128  captured Dout; ct_valid  out  1  one-cycle result pulse.
- err_timeout  out  1  one-cycle pulse on timeout abort.
- Kin  out  128; Din  out  496; Krdy, Drdy, EN  out  1: to core.
- Kvld, Dvld, BSY  in  1; Dout  in  128: from core. BSY is ignored.

## Operation
- FSM states: IDLE, KREQ, KWAIT, FILL, LOAD, HOLD, WAIT.
- IDLE:
  - key_ready=1 and pt_ready=1 only here.
  - key_valid has priority over pt_valid when both are high.
  - Key transfer: latch key_data into the Kin register, go to KREQ.
  - Plaintext transfer: latch pt_data into Din[127:0], clear lane counter, go to FILL.
  - seed_ld with a zero seed loads SEED_RST instead.
- KREQ: Krdy=1 for exactly one cycle, then KWAIT.
- KWAIT: wait for Kvld=1, then IDLE. No timeout here; Kvld is the core's one-cycle echo.
- FILL: 23 cycles.
  - Each cycle, LFSR advances once and its low 16 bits go to lane i: Din[495-16i -: 16], i=0..22.
  - After lane 22, go to LOAD.
- LOAD: Drdy=1 for exactly one cycle. The core latches randomness and Kin here. Next state HOLD.
- HOLD: Drdy=0, one cycle. The core latches Din[127:0] here. Next state WAIT.
- WAIT:
  - On Dvld=1: ct_data<=Dout, ct_valid pulses next cycle, return to IDLE.
  - If the counter reaches TIMEOUT first: err_timeout pulses, ct_data is unchanged, return to IDLE.
- Kin and Din hold their values from LOAD until the next transfer. They are never changed while in LOAD/HOLD/WAIT.
- Dvld outside WAIT is ignored. Kvld outside KWAIT is ignored.
- A plaintext without a prior key load is legal and uses Kin as-is; reset value is 0.
- LFSR:
  - 32-bit Galois, polynomial x^32+x^22+x^2+x+1, shifts right, tap mask 32'h8020_0003.
  - Advances only in FILL.
  - Never reaches zero.

## Timing
- Reset values: state IDLE, EN=0, Krdy=0, Drdy=0, ct_valid=0, err_timeout=0, Kin=0, Din=0, ct_data=0, LFSR=SEED_RST, key_ready=1, pt_ready=1.
- EN is a register: 0 during reset, 1 from the first clock edge after reset release onward.
- Key load: transfer at cycle t, Krdy high in t+1, Kvld expected at t+2, key_ready high again at t+3.
- Plaintext:
  - Transfer at t, FILL t+1..t+23, Drdy at t+24, HOLD t+25, WAIT from t+26.
  - With the core's nominal 10-cycle Dvld latency after Drdy, Dvld arrives at t+34 and ct_valid pulses at t+35.
- Timeout counter: 16 bits, cleared on WAIT entry, increments each WAIT cycle, saturates.
- If Dvld and the count reaching TIMEOUT fall in the same cycle, Dvld wins: ct_valid, no error.
- Asynchronous reset mid-operation: all outputs go to reset values immediately; any in-flight operation is dropped with no result.

## Structure
- Package aes_host_pkg holds:
  - state enum;
  - LANES=23, LANE_W=16, DIN_W=496;
  - LFSR tap mask;
  - lane offset function 495-16*i.
- Sub-module aes_host_lfsr: seed load, enable, 32-bit state output.

## Test plan
- Key load: key_data=128'h000102..0f -> Krdy one cycle, Kin=000102..0f held, key_ready back 3 cycles after transfer.
- Plaintext: pt_data=128'h00112233..eeff; bench responder returns Dout=128'hDEADBEEF_0123... 10 cycles after Drdy.
  - Din[127:0] stable through HOLD.
  - ct_data=DEADBEEF_0123... and ct_valid pulse at t+35.
- Randomness: seed 32'h1 -> 23 lanes match the reference LFSR model in order, lane 0 at Din[495:480].
  - Back-to-back plaintexts get different lanes.
- Timeout: responder never asserts Dvld.
  - err_timeout pulses TIMEOUT cycles after WAIT entry.
  - ct_valid stays 0, ct_data unchanged, next plaintext accepted.
- Priority/ignore:
  - key_valid and pt_valid both high in IDLE -> key taken first.
  - Spurious Dvld during FILL -> no ct_valid.
  - Dvld in the same cycle as timeout -> result, not error.
- Reset in WAIT:
  - RSTn low mid-op -> EN/Drdy/ct_valid drop to 0 immediately.
  - After release: IDLE, LFSR=SEED_RST, no stale result.
